// File: rtl/matmult_result_buffer_pkg.sv
// Shared types and default sizing for the matmult result write-back buffer.
// Defaults mirror the kernel's output width / address width / write count.
package matmult_result_buffer_pkg;
  localparam int DEF_OUT_W    = 32;
  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_NRESULTS = 256;
  localparam int DEF_STREAM_W = 16;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_t;
endpackage

// File: rtl/matmult_result_bank_ram.sv
// Simple dual-port result memory: one write port, one registered read port.
// The lower NRESULTS words hold bank 0, the upper NRESULTS words hold bank 1.
module result_bank_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Wr_en,
  input  logic [AW-1:0]     Wr_addr,
  input  logic [DATA_W-1:0] Wr_data,
  input  logic              Rd_en,
  input  logic [AW-1:0]     Rd_addr,
  output logic [DATA_W-1:0] Rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (Wr_en) mem[Wr_addr] <= Wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Rd_en) Rd_data <= mem[Rd_addr];
  end
endmodule

// File: rtl/matmult_result_buffer.sv
// Ping-pong write-back buffer behind the matmult kernel: fills one bank while the
// other drains in address order on a saturating valid/ready stream.
module matmult_result_buffer
  import matmult_result_buffer_pkg::*;
#(
  parameter int OUT_W    = DEF_OUT_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRESULTS = DEF_NRESULTS,
  parameter int STREAM_W = DEF_STREAM_W
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Wr_en,
  input  logic [ADDR_W-1:0]   Wr_addr,
  input  logic [OUT_W-1:0]    C,
  output logic                Buf_ready,
  output logic                Frame_done,
  output logic                Overrun,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic [STREAM_W-1:0] Out_data,
  output logic [ADDR_W-1:0]   Out_addr,
  output logic                Out_last,
  output logic                Out_sat
);
  localparam int RAM_DEPTH = 2 * NRESULTS;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam int CNT_W     = $clog2(NRESULTS + 1);
  localparam logic signed [OUT_W-1:0] SAT_MAX = {{(OUT_W-STREAM_W+1){1'b0}}, {(STREAM_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [RAM_AW-1:0] bank_addr(input logic bank, input logic [ADDR_W-1:0] idx);
    return bank ? RAM_AW'(idx) + RAM_AW'(NRESULTS) : RAM_AW'(idx);
  endfunction

  logic              full_reg [2];
  logic              wr_bank_reg, rd_bank_reg;
  logic [CNT_W-1:0]  wr_count_reg, rd_idx_reg;
  logic              frame_done_reg, overrun_reg;
  rd_state_t         rd_state_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_addr_reg;
  logic [1:0]        fifo_count_reg;
  logic              fifo_wptr_reg, fifo_rptr_reg;
  logic [STREAM_W-1:0] fifo_data_reg [2];
  logic [ADDR_W-1:0]   fifo_addr_reg [2];
  logic                fifo_last_reg [2];
  logic                fifo_sat_reg  [2];

  logic wr_blocked, wr_accept, wr_last;
  logic pop, drain_done, issue_ok, rd_issue;
  logic [1:0] occ_next;
  logic [OUT_W-1:0] ram_rd_data;
  logic signed [OUT_W-1:0] rd_signed;
  logic [STREAM_W-1:0] sat_data;
  logic sat_flag;

  assign wr_blocked = full_reg[wr_bank_reg];
  assign wr_accept  = Wr_en && !wr_blocked && (32'(Wr_addr) < 32'(NRESULTS));
  assign wr_last    = wr_accept && (wr_count_reg == CNT_W'(NRESULTS - 1));

  assign Buf_ready  = !full_reg[wr_bank_reg] && (wr_count_reg == '0);
  assign Frame_done = frame_done_reg;
  assign Overrun    = overrun_reg;
  assign Out_valid  = (fifo_count_reg != 2'd0);
  assign Out_data   = fifo_data_reg[fifo_rptr_reg];
  assign Out_addr   = fifo_addr_reg[fifo_rptr_reg];
  assign Out_last   = fifo_last_reg[fifo_rptr_reg];
  assign Out_sat    = fifo_sat_reg[fifo_rptr_reg];

  assign pop        = Out_valid && Out_ready;
  assign drain_done = pop && Out_last;

  // The first read is issued on the IDLE->STREAM transition so the first beat lands two cycles after full.
  always_comb begin
    issue_ok = 1'b0;
    if (rd_state_reg == RD_IDLE) issue_ok = full_reg[rd_bank_reg];
    else                         issue_ok = (rd_idx_reg != CNT_W'(NRESULTS));
    // Occupancy after this cycle's pop plus the returning read; keeps the FIFO from ever overflowing.
    occ_next = fifo_count_reg + {1'b0, inflight_reg} - {1'b0, pop};
    rd_issue = issue_ok && (occ_next < 2'd2);
  end

  assign rd_signed = ram_rd_data;
  always_comb begin
    sat_flag = 1'b0;
    sat_data = rd_signed[STREAM_W-1:0];
    if (rd_signed > SAT_MAX) begin
      sat_data = SAT_MAX[STREAM_W-1:0];
      sat_flag = 1'b1;
    end else if (rd_signed < SAT_MIN) begin
      sat_data = SAT_MIN[STREAM_W-1:0];
      sat_flag = 1'b1;
    end
  end

  result_bank_ram #(.DATA_W(OUT_W), .DEPTH(RAM_DEPTH), .AW(RAM_AW)) u_ram (
    .Clk     (Clk),
    .Wr_en   (wr_accept),
    .Wr_addr (bank_addr(wr_bank_reg, Wr_addr)),
    .Wr_data (C),
    .Rd_en   (rd_issue),
    .Rd_addr (bank_addr(rd_bank_reg, ADDR_W'(rd_idx_reg))),
    .Rd_data (ram_rd_data)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_bank_reg    <= 1'b0;
      wr_count_reg   <= '0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_done_reg <= wr_last;
      if (Wr_en && wr_blocked) overrun_reg <= 1'b1;
      if (wr_accept) begin
        if (wr_last) begin
          wr_count_reg <= '0;
          wr_bank_reg  <= ~wr_bank_reg;
        end else begin
          wr_count_reg <= wr_count_reg + 1'b1;
        end
      end
    end
  end

  // Fill and drain always target different banks, so both may land in the same cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    always_ff @(posedge Clk) begin
      if (!Rst_n)                                        full_reg[gi] <= 1'b0;
      else if (wr_last && (wr_bank_reg == 1'(gi)))       full_reg[gi] <= 1'b1;
      else if (drain_done && (rd_bank_reg == 1'(gi)))    full_reg[gi] <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rd_state_reg      <= RD_IDLE;
      rd_bank_reg       <= 1'b0;
      rd_idx_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
      fifo_count_reg    <= 2'd0;
      fifo_wptr_reg     <= 1'b0;
      fifo_rptr_reg     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_addr_reg[i] <= '0;
        fifo_last_reg[i] <= 1'b0;
        fifo_sat_reg[i]  <= 1'b0;
      end
    end else begin
      inflight_reg <= rd_issue;
      if (rd_issue) begin
        inflight_addr_reg <= ADDR_W'(rd_idx_reg);
        rd_idx_reg        <= rd_idx_reg + 1'b1;
      end
      case (rd_state_reg)
        RD_IDLE:   if (full_reg[rd_bank_reg]) rd_state_reg <= RD_STREAM;
        RD_STREAM: if (drain_done) begin
          rd_state_reg <= RD_IDLE;
          rd_bank_reg  <= ~rd_bank_reg;
          rd_idx_reg   <= '0;
        end
        default:   rd_state_reg <= RD_IDLE;
      endcase
      if (inflight_reg) begin
        fifo_data_reg[fifo_wptr_reg] <= sat_data;
        fifo_addr_reg[fifo_wptr_reg] <= inflight_addr_reg;
        fifo_last_reg[fifo_wptr_reg] <= (inflight_addr_reg == ADDR_W'(NRESULTS - 1));
        fifo_sat_reg[fifo_wptr_reg]  <= sat_flag;
        fifo_wptr_reg                <= ~fifo_wptr_reg;
      end
      if (pop) fifo_rptr_reg <= ~fifo_rptr_reg;
      fifo_count_reg <= occ_next;
    end
  end
endmodule
